debounce: RTL and testbench
===========================

# debounce

Tick-driven input debouncer that sits directly downstream of the periodic strobe timer. It consumes the strobe's one-cycle `act` pulse as its sampling tick and synchronises a raw asynchronous input (button, switch, open-drain line) into the clock domain. It accepts a new level only after the input has held stable for N consecutive ticks. It produces a clean level plus one-cycle rise/fall event pulses for downstream logic.

## Interface

Parameters:
- `W`, default 4: width of the stability counter.
- `N`, default 8: number of consecutive ticks a new level must hold before it is accepted. Legal range is 1..2^W-1.
- `INIT`, default 0: reset value of the synchroniser stages and of `out`.

Ports:
- `clock`, input, 1 bit: single clock; all state is updated on its rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset for all state.
- `tick`, input, 1 bit: sampling strobe. One cycle wide per period; it may also be held high to sample every clock.
- `in`, input, 1 bit: raw input, asynchronous to `clock`.
- `out`, output, 1 bit: debounced level, registered.
- `rise`, output, 1 bit: one-cycle pulse when `out` changes from 0 to 1, registered.
- `fall`, output, 1 bit: one-cycle pulse when `out` changes from 1 to 0, registered.

## Operation

- **Synchroniser:** `in` passes through two flip-flops to give `s`. Both stages reset to `INIT`.
- **State held:** `s`, `out`, a W-bit `count`, `rise` and `fall`. There is no other FSM; the stable/pending condition is implied by `s != out`.
- **Cycle with `tick` = 0:**
  - `count` and `out` hold.
  - `rise` and `fall` are 0.
- **Cycle with `tick` = 1 and `s == out`:**
  - `count` is set to 0, discarding a partial run (bounce).
  - `rise` and `fall` are 0.
- **Cycle with `tick` = 1, `s != out` and `count == N-1`:**
  - `out` is set to `s` and `count` is set to 0.
  - `rise` is set to `s` and `fall` is set to `!s`.
- **Cycle with `tick` = 1, `s != out` and `count < N-1`:**
  - `count` increments by 1.
  - `rise` and `fall` are 0.
- **Arithmetic:**
  - `count` never exceeds N-1, so it cannot wrap.
  - The comparison is W-bit unsigned.
  - With N=1, a differing sample is accepted on the first tick.
- **Illegal parameters:** N=0 or N≥2^W is a parameter error. It is caught by an elaboration-time check that uses `$error` inside a generate block.
- **Simultaneous events:** `in` changing in the same cycle as `tick` has no special effect. The decision always uses the already-synchronised `s` (the value before the edge).

## Timing

- **Reset values while `reset` is low:**
  - Synchroniser stages and `out` are `INIT`.
  - `count` is 0.
  - `rise` and `fall` are 0.
- **Reset release:** the first state update occurs on the first rising `clock` edge after `reset` goes high.
- **Reset mid-operation:** all state clears immediately and asynchronously, including a partial run. No `rise`/`fall` pulse is produced by reset.
- **Synchroniser latency:** a level change on `in` reaches `s` after 2 `clock` edges.
- **Acceptance latency:** `out` changes on the edge of the N-th tick that samples the new `s`. `rise`/`fall` is high for exactly that following cycle, aligned with the new `out`.
- **Tick held high:** worst-case acceptance is 2+N clocks from the `in` change.
- **Repeated changes:** back-to-back accepted changes are at least N ticks apart. Therefore `rise` and `fall` are never high together and never high on consecutive cycles unless N=1 and `tick` is continuous.

## Structure

- **Sub-module:** `sync2`, a two-flop synchroniser with parameter `INIT`, ports `clock`, `reset`, `d`, `q`, and asynchronous active-low reset.
  - It lives in its own include-guarded file alongside the timer blocks so other modules can reuse it.
- **Shared package:** none needed. `W`, `N` and `INIT` are local parameters of the block, and there are no shared typedefs.
- **Typical top-level hookup:**
  - The strobe's `act` drives `tick`.
  - A 1 kHz strobe with N=8 gives a debounce window of about 8 ms.

## Test plan

1. **Reset:** assert `reset`=0 with `in`=1 and INIT=0, then release. Required: `out`=0, `rise`=`fall`=0, `count`=0; with `in` held at 1, `out` becomes 1 exactly after 2 clocks plus 8 ticks.
2. **Clean press, continuous tick:** N=8, `tick`=1 constantly, `in` 0→1 at cycle 10. Required: `out`=1 and `rise`=1 at cycle 20, `rise`=0 at cycle 21, `fall` never asserted.
3. **Bounce rejection:** `tick` every 4 clocks, `in` toggles 1 for 3 ticks, 0 for 1 tick, then 1 steady. Required: no `out` change until 8 consecutive ticks of 1 after the last 0; exactly one `rise`.
4. **No tick:** `in` changes and `tick` is held at 0 for 100 clocks. Required: `out` and `count` unchanged. When ticks then resume, acceptance occurs after 8 ticks.
5. **Reset mid-count:** `in`=1, 5 ticks elapsed, then `reset` pulsed low for 1 clock. Required: `count`=0 and `out`=INIT immediately. After release, a full 2+8 latency applies again.
6. **N=1 edge case:** N=1, W=1, single tick pulses. Required: `out` follows `s` on the first tick after each change, with one `rise`/`fall` pulse per transition.

Source files
------------

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a single asynchronous input bit
`ifndef SYNC2_SV
`define SYNC2_SV

module sync2 #(
  parameter logic INIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`endif

// File: rtl/debounce.sv
// rtl/debounce.sv - tick-sampled debouncer: accepts a new level after N consecutive ticks
module debounce #(
  parameter int   W    = 4,
  parameter int   N    = 8,
  parameter logic INIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  generate
    if (N < 1 || N > (1 << W) - 1) begin : g_bad_params
      $error("debounce: N must lie in 1..2**W-1");
    end
  endgenerate

  logic         s;
  logic [W-1:0] count;

  sync2 #(.INIT(INIT)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (in),
    .q     (s)
  );

  // A run is pending whenever s differs from out; an agreeing tick discards it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out   <= INIT;
      count <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (s == out) begin
          count <= '0;
        end else if (count == LAST) begin
          out   <= s;
          count <= '0;
          rise  <= s;
          fall  <= !s;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce.sv
// tb/tb_debounce.sv - scoreboard bench for debounce (N=8/W=4 and N=1/W=1 instances)
module tb_debounce;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic tick_a = 1'b0, in_a = 1'b0, tick_b = 1'b0, in_b = 1'b0;
  logic out_a, rise_a, fall_a, out_b, rise_b, fall_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int   c;
    logic r;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  debounce #(.W(4), .N(8), .INIT(1'b0)) dut_a (
    .clock (clock), .reset (reset), .tick (tick_a), .in (in_a),
    .out   (out_a), .rise  (rise_a), .fall (fall_a)
  );

  debounce #(.W(1), .N(1), .INIT(1'b0)) dut_b (
    .clock (clock), .reset (reset), .tick (tick_b), .in (in_b),
    .out   (out_b), .rise  (rise_b), .fall (fall_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void expect_a(input int c, input logic r);
    q_a.push_back('{c, r});
  endfunction

  function automatic void expect_b(input int c, input logic r);
    q_b.push_back('{c, r});
  endfunction

  task automatic step(input logic ta, input logic ia, input logic tb, input logic ib);
    @(negedge clock);
    tick_a = ta;
    in_a   = ia;
    tick_b = tb;
    in_b   = ib;
  endtask

  // Monitors: every rise/fall pulse must match the next scheduled event.
  always @(negedge clock) begin
    if (rise_a || fall_a) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_pulse", {30'd0, rise_a, fall_a}, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_pulse_cycle", cyc, e.c);
        chk("a_pulse_kind", {29'd0, rise_a, fall_a, out_a}, {29'd0, e.r, !e.r, e.r});
      end
    end
  end

  always @(negedge clock) begin
    if (rise_b || fall_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_pulse", {30'd0, rise_b, fall_b}, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_pulse_cycle", cyc, e.c);
        chk("b_pulse_kind", {29'd0, rise_b, fall_b, out_b}, {29'd0, e.r, !e.r, e.r});
      end
    end
  end

  initial begin
    int base;
    logic v;

    // Reset held with in=1: everything at INIT / zero
    in_a = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_out", out_a, 0);
    chk("reset_rise", rise_a, 0);
    chk("reset_fall", fall_a, 0);
    chk("reset_count", dut_a.count, 0);
    chk("reset_out_b", out_b, 0);

    // Release: in already 1, continuous tick -> accept after 2+8 edges
    step(1, 1, 0, 0);
    reset = 1'b1;
    expect_a(cyc + 10, 1'b1);
    repeat (11) step(1, 1, 0, 0);
    chk("t1_out", out_a, 1);

    // Clean fall then clean press with continuous tick
    step(1, 0, 0, 0);
    expect_a(cyc + 10, 1'b0);
    repeat (12) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    expect_a(cyc + 10, 1'b1);
    repeat (12) step(1, 1, 0, 0);
    chk("t2_out", out_a, 1);

    // Bounce: tick every 4 clocks, in = 1,1,1,0 then steady 1
    step(1, 0, 0, 0);
    expect_a(cyc + 10, 1'b0);
    repeat (12) step(1, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      v = (k == 3) ? 1'b0 : 1'b1;
      for (int j = 0; j < 4; j++) begin
        step(j == 3, v, 0, 0);
        if (k == 0 && j == 0) begin
          base = cyc;
          expect_a(base + 48, 1'b1);
        end
        if (k == 10 && j == 3) chk("t3_out_held", out_a, 0);
      end
    end
    chk("t3_out", out_a, 1);

    // No tick for 100 clocks: nothing moves; resumed ticks accept after 8
    repeat (100) step(0, 0, 0, 0);
    chk("t4_out_held", out_a, 1);
    chk("t4_count_held", dut_a.count, 0);
    step(1, 0, 0, 0);
    expect_a(cyc + 8, 1'b0);
    repeat (10) step(1, 0, 0, 0);
    chk("t4_out", out_a, 0);

    // Reset mid-count: out=1, in=0, 5 ticks counted, then reset for 1 clock
    step(1, 1, 0, 0);
    expect_a(cyc + 10, 1'b1);
    repeat (12) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (7) step(1, 0, 0, 0);
    chk("t5_count_partial", dut_a.count, 5);
    chk("t5_out_before", out_a, 1);
    reset = 1'b0;
    #1;
    chk("t5_out_async", out_a, 0);
    chk("t5_count_async", dut_a.count, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    reset = 1'b1;
    expect_a(cyc + 10, 1'b1);
    repeat (12) step(1, 1, 0, 0);
    chk("t5_out", out_a, 1);

    // N=1: single tick pulses every 3 clocks, in_b = 1,1,0,1,0,0
    for (int k = 0; k < 6; k++) begin
      v = (k == 2 || k >= 4) ? 1'b0 : 1'b1;
      for (int j = 0; j < 3; j++) begin
        step(0, 1, j == 2, v);
        if (k == 0 && j == 0) begin
          base = cyc;
          expect_b(base + 3, 1'b1);
          expect_b(base + 9, 1'b0);
          expect_b(base + 12, 1'b1);
          expect_b(base + 15, 1'b0);
        end
      end
    end
    chk("t6_out_b", out_b, 0);

    // N=1 with continuous tick: one-cycle glitch gives back-to-back rise/fall
    step(0, 1, 1, 1);
    expect_b(cyc + 3, 1'b1);
    expect_b(cyc + 4, 1'b0);
    step(0, 1, 1, 0);
    repeat (6) step(0, 1, 1, 0);
    repeat (3) step(0, 1, 0, 0);

    chk("a_events_left", q_a.size(), 0);
    chk("b_events_left", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
